// File: rtl/abft_mm_param_if.sv
// rtl/abft_mm_param_if.sv - operand and result stream bundle for abft_mm_param
// Purpose: groups the operand beat stream and the Q row drain stream.
// Signals:
//   in_valid/in_ready/in_last/a_col/b_row   operand beat stream (feeder -> engine)
//   out_valid/out_ready/out_idx/out_row     Q row stream (engine -> consumer)
// Modports: master = feeder/consumer side, slave = engine side.
interface abft_mm_param_if #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = 20
);
    localparam int IW = $clog2(N);

    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [N*DW-1:0]   a_col;
    logic [N*DW-1:0]   b_row;
    logic              out_valid;
    logic              out_ready;
    logic [IW-1:0]     out_idx;
    logic [N*AW-1:0]   out_row;

    modport master (
        output in_valid, in_last, a_col, b_row, out_ready,
        input  in_ready, out_valid, out_idx, out_row
    );

    modport slave (
        input  in_valid, in_last, a_col, b_row, out_ready,
        output in_ready, out_valid, out_idx, out_row
    );
endinterface

// File: rtl/abft_mm_param.sv
// rtl/abft_mm_param.sv - parametrised ABFT outer-product matrix-multiply engine
// Purpose: accumulates Q = sum_k a_k * b_k^T with row/column checksums, verifies them at
//   end of job, locates a single faulty element, optionally repairs it, then drains Q by rows.
// Ports:
//   clk, rst (sync, active high), start (job start pulse, IDLE only)
//   inj_en/inj_row/inj_col/inj_mask  fault injection into Q during ACCUM
//   bus (slave)  operand stream in, Q row stream out
//   busy, error, err_row, err_col, err_multi, corrected  status flags
// Configuration macro: ABFT_CORRECT_EN enables the single-error CORRECT state.
module abft_mm_param #(
    parameter  int N  = 4,
    parameter  int DW = 8,
    parameter  int AW = 20,
    localparam int IW = $clog2(N),
    localparam int CW = AW + $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             inj_en,
    input  logic [IW-1:0]    inj_row,
    input  logic [IW-1:0]    inj_col,
    input  logic [AW-1:0]    inj_mask,
    abft_mm_param_if.slave   bus,
    output logic             busy,
    output logic             error,
    output logic [IW-1:0]    err_row,
    output logic [IW-1:0]    err_col,
    output logic             err_multi,
    output logic             corrected
);
    typedef enum logic [2:0] {IDLE, ACCUM, CHECK, EVAL, CORRECT, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   q_q    [N][N];
    logic [AW-1:0]   q_d    [N][N];
    logic [CW-1:0]   rchk_q [N];
    logic [CW-1:0]   rchk_d [N];
    logic [CW-1:0]   cchk_q [N];
    logic [CW-1:0]   cchk_d [N];
    logic [CW-1:0]   cact_q [N];
    logic [CW-1:0]   cact_d [N];
    logic [N-1:0]    rbad_q, rbad_d;
    logic            error_q, error_d, multi_q, multi_d, corr_q, corr_d;
    logic [IW-1:0]   err_row_q, err_row_d, err_col_q, err_col_d;

    // Scratch values used only inside the next-state block.
    logic [CW-1:0]   sum_a, sum_b, rsum;
    logic [N-1:0]    cbad;
    int              n_r, n_c;
    logic [IW-1:0]   pos_r, pos_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rbad_q    <= '0;
            error_q   <= 1'b0;
            multi_q   <= 1'b0;
            corr_q    <= 1'b0;
            err_row_q <= '0;
            err_col_q <= '0;
            for (int i = 0; i < N; i++) begin
                rchk_q[i] <= '0;
                cchk_q[i] <= '0;
                cact_q[i] <= '0;
                for (int j = 0; j < N; j++) q_q[i][j] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rbad_q    <= rbad_d;
            error_q   <= error_d;
            multi_q   <= multi_d;
            corr_q    <= corr_d;
            err_row_q <= err_row_d;
            err_col_q <= err_col_d;
            rchk_q    <= rchk_d;
            cchk_q    <= cchk_d;
            cact_q    <= cact_d;
            q_q       <= q_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        rchk_d    = rchk_q;
        cchk_d    = cchk_q;
        cact_d    = cact_q;
        rbad_d    = rbad_q;
        error_d   = error_q;
        multi_d   = multi_q;
        corr_d    = corr_q;
        err_row_d = err_row_q;
        err_col_d = err_col_q;
        sum_a     = '0;
        sum_b     = '0;
        rsum      = '0;
        cbad      = '0;
        n_r       = 0;
        n_c       = 0;
        pos_r     = '0;
        pos_c     = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ACCUM;
                    cnt_d     = '0;
                    rbad_d    = '0;
                    error_d   = 1'b0;
                    multi_d   = 1'b0;
                    corr_d    = 1'b0;
                    err_row_d = '0;
                    err_col_d = '0;
                    for (int i = 0; i < N; i++) begin
                        rchk_d[i] = '0;
                        cchk_d[i] = '0;
                        cact_d[i] = '0;
                        for (int j = 0; j < N; j++) q_d[i][j] = '0;
                    end
                end
            end
            ACCUM: begin
                if (bus.in_valid) begin
                    for (int i = 0; i < N; i++) begin
                        sum_a = sum_a + CW'(bus.a_col[i*DW +: DW]);
                        sum_b = sum_b + CW'(bus.b_row[i*DW +: DW]);
                    end
                    for (int i = 0; i < N; i++) begin
                        // Row checksum gets a[i]*sum(b); column checksum gets b[j]*sum(a),
                        // so they track the row/column sums of Q independently of Q itself.
                        rchk_d[i] = rchk_q[i] + CW'(bus.a_col[i*DW +: DW]) * sum_b;
                        cchk_d[i] = cchk_q[i] + CW'(bus.b_row[i*DW +: DW]) * sum_a;
                        for (int j = 0; j < N; j++)
                            q_d[i][j] = q_q[i][j] + AW'(bus.a_col[i*DW +: DW]) * AW'(bus.b_row[j*DW +: DW]);
                    end
                    if (bus.in_last) begin
                        state_d = CHECK;
                        cnt_d   = '0;
                    end
                end
                // Injection lands after this cycle's accumulate and bypasses the checksums.
                if (inj_en) q_d[inj_row][inj_col] = q_d[inj_row][inj_col] ^ inj_mask;
            end
            CHECK: begin
                for (int j = 0; j < N; j++) begin
                    rsum      = rsum + CW'(q_q[cnt_q][j]);
                    cact_d[j] = cact_q[j] + CW'(q_q[cnt_q][j]);
                end
                rbad_d[cnt_q] = (rsum != rchk_q[cnt_q]);
                if (cnt_q == IW'(N-1)) begin
                    state_d = EVAL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EVAL: begin
                for (int i = 0; i < N; i++) begin
                    cbad[i] = (cact_q[i] != cchk_q[i]);
                    if (rbad_q[i]) begin
                        n_r   = n_r + 1;
                        pos_r = IW'(i);
                    end
                    if (cbad[i]) begin
                        n_c   = n_c + 1;
                        pos_c = IW'(i);
                    end
                end
                state_d = DRAIN;
                cnt_d   = '0;
                if (n_r == 1 && n_c == 1) begin
                    error_d   = 1'b1;
                    err_row_d = pos_r;
                    err_col_d = pos_c;
`ifdef ABFT_CORRECT_EN
                    state_d   = CORRECT;
`endif
                end else if (n_r != 0 || n_c != 0) begin
                    error_d   = 1'b1;
                    multi_d   = 1'b1;
                    err_row_d = '0;
                    err_col_d = '0;
                end
            end
`ifdef ABFT_CORRECT_EN
            CORRECT: begin
                // Column checksum minus actual column sum is exactly the missing amount.
                q_d[err_row_q][err_col_q] = q_q[err_row_q][err_col_q]
                                          + AW'(cchk_q[err_col_q] - cact_q[err_col_q]);
                corr_d  = 1'b1;
                state_d = DRAIN;
            end
`endif
            DRAIN: begin
                if (bus.out_ready) begin
                    if (cnt_q == IW'(N-1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_q != IDLE);
        bus.in_ready  = (state_q == ACCUM);
        bus.out_valid = (state_q == DRAIN);
        bus.out_idx   = cnt_q;
        bus.out_row   = '0;
        for (int j = 0; j < N; j++) bus.out_row[j*AW +: AW] = q_q[cnt_q][j];
    end

    assign error     = error_q;
    assign err_multi = multi_q;
    assign err_row   = err_row_q;
    assign err_col   = err_col_q;
    assign corrected = corr_q;
endmodule

// File: tb/tb_abft_mm_param.sv
// tb/tb_abft_mm_param.sv - self-checking bench for abft_mm_param
module tb_abft_mm_param;
    localparam int N = 4, DW = 8, AW = 20, IW = 2, CW = AW + 2;

    logic clk = 1'b0;
    logic rst, start, inj_en;
    logic [IW-1:0] inj_row, inj_col;
    logic [AW-1:0] inj_mask;
    logic busy, error, err_multi, corrected;
    logic [IW-1:0] err_row, err_col;

    abft_mm_param_if #(.N(N), .DW(DW), .AW(AW)) bus();

    abft_mm_param #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .inj_en(inj_en),
        .inj_row(inj_row), .inj_col(inj_col), .inj_mask(inj_mask), .bus(bus),
        .busy(busy), .error(error), .err_row(err_row), .err_col(err_col),
        .err_multi(err_multi), .corrected(corrected)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint unsigned tq [N][N];      // exact product sums (what checksums describe)
    logic [AW-1:0]   mq [N][N];      // Q as it should be held, injections included
    logic [N*AW-1:0] exp_rows [N];
    logic [N*AW-1:0] dut_rows [N];
    logic e_err, e_multi, e_corr;
    int e_r, e_c, exp_idx;

    function automatic longint unsigned elem(input logic [N*DW-1:0] v, input int i);
        return longint'(v[i*DW +: DW]);
    endfunction

    function automatic logic [N*DW-1:0] mk(input int e0, input int e1, input int e2, input int e3);
        logic [N*DW-1:0] r;
        r = {e3[DW-1:0], e2[DW-1:0], e1[DW-1:0], e0[DW-1:0]};
        return r;
    endfunction

    function automatic logic [N*AW-1:0] row4(input int e0, input int e1, input int e2, input int e3);
        logic [N*AW-1:0] r;
        r = {e3[AW-1:0], e2[AW-1:0], e1[AW-1:0], e0[AW-1:0]};
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            dut_rows[i] = '0;
            exp_rows[i] = '0;
            for (int j = 0; j < N; j++) begin
                tq[i][j] = 0;
                mq[i][j] = '0;
            end
        end
        exp_idx = 0;
    endtask

    task automatic model_beat(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
        longint unsigned p;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                p = elem(a, i) * elem(b, j);
                tq[i][j] += p;
                mq[i][j] = mq[i][j] + p[AW-1:0];
            end
    endtask

    task automatic model_eval();
        longint unsigned cmask, rt, rq, ct, cq, delta;
        int nr, nc;
        logic [AW-1:0] fix;
        cmask = (longint'(1) << CW) - 1;
        nr = 0; nc = 0; e_r = 0; e_c = 0; delta = 0;
        for (int i = 0; i < N; i++) begin
            rt = 0; rq = 0; ct = 0; cq = 0;
            for (int j = 0; j < N; j++) begin
                rt += tq[i][j]; rq += mq[i][j];
                ct += tq[j][i]; cq += mq[j][i];
            end
            if ((rt & cmask) != (rq & cmask)) begin nr++; e_r = i; end
            if ((ct & cmask) != (cq & cmask)) begin nc++; e_c = i; delta = ct - cq; end
        end
        e_err = (nr != 0) || (nc != 0);
        e_multi = e_err && !(nr == 1 && nc == 1);
        if (e_multi) begin e_r = 0; e_c = 0; end
        e_corr = 1'b0;
`ifdef ABFT_CORRECT_EN
        if (e_err && !e_multi) begin
            fix = delta[AW-1:0];
            mq[e_r][e_c] = mq[e_r][e_c] + fix;
            e_corr = 1'b1;
        end
`endif
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) exp_rows[i][j*AW +: AW] = mq[i][j];
    endtask

    // ---------------- drain compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid) begin
                if (exp_idx < N) begin
                    chk("out_idx", 128'(bus.out_idx), 128'(exp_idx));
                    chk("out_row", 128'(bus.out_row), 128'(exp_rows[exp_idx]));
                    if (bus.out_ready) dut_rows[exp_idx] = bus.out_row;
                end else begin
                    chk("drain_overrun_rows", 128'(exp_idx), 128'(N - 1));
                end
                if (bus.out_ready) exp_idx++;
            end
        end
    end

    int rmode = 0;
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        bit v; bit last;
        logic [N*DW-1:0] a; logic [N*DW-1:0] b;
        bit inj; int r; int c; logic [AW-1:0] m;
    } step_t;
    step_t steps[$];

    task automatic add_step(input bit v, input bit last, input logic [N*DW-1:0] a,
                            input logic [N*DW-1:0] b, input bit inj, input int r,
                            input int c, input logic [AW-1:0] m);
        step_t s;
        s.v = v; s.last = last; s.a = a; s.b = b; s.inj = inj; s.r = r; s.c = c; s.m = m;
        steps.push_back(s);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_clear();
    endtask

    task automatic run_steps(input bit eval);
        foreach (steps[s]) begin
            bus.in_valid = steps[s].v;
            bus.in_last  = steps[s].last;
            bus.a_col    = steps[s].a;
            bus.b_row    = steps[s].b;
            inj_en       = steps[s].inj;
            inj_row      = IW'(steps[s].r);
            inj_col      = IW'(steps[s].c);
            inj_mask     = steps[s].m;
            chk("in_ready_accum", 128'(bus.in_ready), 128'(1));
            tick();
            if (steps[s].v) model_beat(steps[s].a, steps[s].b);
            if (steps[s].inj) mq[steps[s].r][steps[s].c] ^= steps[s].m;
        end
        bus.in_valid = 1'b0; bus.in_last = 1'b0; inj_en = 1'b0;
        steps.delete();
        if (eval) model_eval();
    endtask

    task automatic wait_done(input bit pulse);
        int n;
        n = 0;
        while (1) begin
            start = pulse;
            tick();
            n++;
            if (!busy) break;
            if (n > 400) begin
                checks++; failures++;
                $display("FAIL done_timeout: busy=%0d after %0d cycles, expected 0", busy, n);
                break;
            end
        end
        start = 1'b0;
        chk("rows_drained", 128'(exp_idx), 128'(N));
        chk("error", 128'(error), 128'(e_err));
        chk("err_multi", 128'(err_multi), 128'(e_multi));
        chk("err_row", 128'(err_row), 128'(e_r));
        chk("err_col", 128'(err_col), 128'(e_c));
        chk("corrected", 128'(corrected), 128'(e_corr));
        chk("idle_in_ready", 128'(bus.in_ready), 128'(0));
        chk("idle_out_valid", 128'(bus.out_valid), 128'(0));
    endtask

    task automatic job1(input bit inj, input int r, input int c, input logic [AW-1:0] m, input bit pulse);
        do_start();
        add_step(1, 1, mk(1, 2, 3, 4), mk(5, 10, 15, 10), inj, r, c, m);
        run_steps(1);
        wait_done(pulse);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; inj_en = 1'b0; inj_row = '0; inj_col = '0; inj_mask = '0;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.a_col = '0; bus.b_row = '0;
        model_clear();
        tick(); tick();
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_flags", 128'({error, err_multi, corrected, err_row, err_col}), 128'(0));
        chk("rst_out_row", 128'(bus.out_row), 128'(0));
        rst = 1'b0;
        tick();

        // 1: single beat, clean
        job1(0, 0, 0, '0, 0);
        chk("t1_row0", 128'(dut_rows[0]), 128'(row4(5, 10, 15, 10)));
        chk("t1_row3", 128'(dut_rows[3]), 128'(row4(20, 40, 60, 40)));
        chk("t1_error", 128'(error), 128'(0));

        // 2: single injected fault at (1,2)
        job1(1, 1, 2, 20'h10, 0);
        chk("t2_err_loc", 128'({err_row, err_col, err_multi}), 128'({2'd1, 2'd2, 1'b0}));
`ifdef ABFT_CORRECT_EN
        chk("t2_q12", 128'(dut_rows[1][2*AW +: AW]), 128'(30));
        chk("t2_corrected", 128'(corrected), 128'(1));
`else
        chk("t2_q12", 128'(dut_rows[1][2*AW +: AW]), 128'(14));
        chk("t2_corrected", 128'(corrected), 128'(0));
`endif

        // 3: two faults, one on an idle ACCUM cycle, one on the last beat
        do_start();
        add_step(0, 0, '0, '0, 1, 0, 1, 20'h4);
        add_step(1, 1, mk(1, 2, 3, 4), mk(5, 10, 15, 10), 1, 2, 3, 20'h8);
        run_steps(1);
        wait_done(0);
        chk("t3_multi", 128'({error, err_multi, corrected}), 128'({1'b1, 1'b1, 1'b0}));
        chk("t3_q01", 128'(dut_rows[0][AW +: AW]), 128'(14));
        chk("t3_q23", 128'(dut_rows[2][3*AW +: AW]), 128'(22));

        // 4: 16 full-scale beats with gaps, consumer stalls
        rmode = 1;
        do_start();
        for (int k = 0; k < 16; k++) begin
            if (k % 3 == 1) add_step(0, 0, '0, '0, 0, 0, 0, '0);
            add_step(1, k == 15, {N{8'hFF}}, {N{8'hFF}}, 0, 0, 0, '0);
        end
        run_steps(1);
        wait_done(0);
        chk("t4_model_q00", 128'(mq[0][0]), 128'(1040400));
        chk("t4_q21", 128'(dut_rows[2][AW +: AW]), 128'(1040400));
        chk("t4_row3", 128'(dut_rows[3]), 128'(row4(1040400, 1040400, 1040400, 1040400)));
        rmode = 0;

        // 5: reset mid-job after 2 of 3 beats
        do_start();
        add_step(1, 0, mk(9, 9, 9, 9), mk(7, 7, 7, 7), 0, 0, 0, '0);
        add_step(1, 0, mk(3, 1, 4, 1), mk(5, 9, 2, 6), 0, 0, 0, '0);
        run_steps(0);
        rst = 1'b1;
        tick();
        chk("t5_busy", 128'(busy), 128'(0));
        chk("t5_in_ready", 128'(bus.in_ready), 128'(0));
        rst = 1'b0;
        job1(0, 0, 0, '0, 0);
        chk("t5_row3", 128'(dut_rows[3]), 128'(row4(20, 40, 60, 40)));

        // 6: start held through CHECK/DRAIN must be ignored
        rmode = 1;
        job1(0, 0, 0, '0, 1);
        chk("t6_row1", 128'(dut_rows[1]), 128'(row4(10, 20, 30, 20)));
        tick();
        chk("t6_stays_idle", 128'(busy), 128'(0));
        rmode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
